// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - datapath / opcode widths
//   - opcode encodings (NOP, loads, stores)
//   - FSM state encoding
//   - opcode decode helpers (access size, load/store class, misalignment)
package lsu_pkg;

    localparam int unsigned CpuWidth    = 64;
    localparam int unsigned LsuOptWidth = 4;

    localparam logic [3:0] OptNop = 4'd0;
    localparam logic [3:0] OptLb  = 4'd1;
    localparam logic [3:0] OptLh  = 4'd2;
    localparam logic [3:0] OptLw  = 4'd3;
    localparam logic [3:0] OptLd  = 4'd4;
    localparam logic [3:0] OptLbu = 4'd5;
    localparam logic [3:0] OptLhu = 4'd6;
    localparam logic [3:0] OptLwu = 4'd7;
    localparam logic [3:0] OptSb  = 4'd8;
    localparam logic [3:0] OptSh  = 4'd9;
    localparam logic [3:0] OptSw  = 4'd10;
    localparam logic [3:0] OptSd  = 4'd11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StOut  = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 for anything that is not a memory op.
    function automatic logic [3:0] opt_size(logic [3:0] opt);
        case (opt)
            OptLb, OptLbu, OptSb: return 4'd1;
            OptLh, OptLhu, OptSh: return 4'd2;
            OptLw, OptLwu, OptSw: return 4'd4;
            OptLd, OptSd:         return 4'd8;
            default:              return 4'd0;
        endcase
    endfunction

    function automatic logic is_load(logic [3:0] opt);
        return (opt >= OptLb) && (opt <= OptLwu);
    endfunction

    function automatic logic is_store(logic [3:0] opt);
        return (opt >= OptSb) && (opt <= OptSd);
    endfunction

    // True when the access would spill past the 8-byte bus word.
    function automatic logic misaligned(logic [3:0] opt, logic [2:0] lo);
        logic [4:0] end_byte;
        end_byte = {2'b00, lo} + {1'b0, opt_size(opt)};
        return end_byte > 5'd8;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   opt_i      opcode
//   addr_lo_i  byte offset inside the 8-byte bus word
//   rs2_i      store data (unshifted)
//   rdata_i    raw bus read data
//   wdata_o    store data shifted onto its byte lanes (0 for non-stores)
//   wmask_o    store byte-lane mask (0 for non-stores)
//   load_res_o extracted and sign/zero-extended load value
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned Width = CpuWidth
) (
    input  logic [LsuOptWidth-1:0] opt_i,
    input  logic [2:0]             addr_lo_i,
    input  logic [Width-1:0]       rs2_i,
    input  logic [Width-1:0]       rdata_i,
    output logic [Width-1:0]       wdata_o,
    output logic [7:0]             wmask_o,
    output logic [Width-1:0]       load_res_o
);

    logic [5:0]       shamt;
    logic [7:0]       lanes;
    logic [Width-1:0] shifted;

    assign shamt   = {addr_lo_i, 3'b000};
    assign shifted = rdata_i >> shamt;

    always_comb begin
        lanes = 8'h00;
        case (opt_size(opt_i))
            4'd1:    lanes = 8'h01;
            4'd2:    lanes = 8'h03;
            4'd4:    lanes = 8'h0f;
            4'd8:    lanes = 8'hff;
            default: lanes = 8'h00;
        endcase
    end

    assign wmask_o = is_store(opt_i) ? (lanes << addr_lo_i) : 8'h00;
    assign wdata_o = is_store(opt_i) ? (rs2_i << shamt) : '0;

    always_comb begin
        load_res_o = shifted;
        case (opt_i)
            OptLb:   load_res_o = {{(Width-8){shifted[7]}}, shifted[7:0]};
            OptLh:   load_res_o = {{(Width-16){shifted[15]}}, shifted[15:0]};
            OptLw:   load_res_o = {{(Width-32){shifted[31]}}, shifted[31:0]};
            OptLbu:  load_res_o = {{(Width-8){1'b0}}, shifted[7:0]};
            OptLhu:  load_res_o = {{(Width-16){1'b0}}, shifted[15:0]};
            OptLwu:  load_res_o = {{(Width-32){1'b0}}, shifted[31:0]};
            default: load_res_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit between exu and wbu.
//   i_pre_valid/o_pre_ready    upstream handshake; accepts only in IDLE
//   i_exu_res, i_rs2, i_lsu_opt address/result, store data, opcode
//   i_rd_idx, i_rd_wen         sideband, registered through to o_rd_idx/o_rd_wen
//   o_post_valid/i_post_ready  downstream handshake with o_lsu_res, o_misalign
//   o_mem_*/i_mem_*            single-beat 64-bit memory request/response
// One memory transaction per instruction; misaligned accesses and NOPs skip memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned CPU_WIDTH     = CpuWidth,
    parameter int unsigned LSU_OPT_WIDTH = LsuOptWidth
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pre_valid,
    output logic                     o_pre_ready,
    input  logic [CPU_WIDTH-1:0]     i_exu_res,
    input  logic [CPU_WIDTH-1:0]     i_rs2,
    input  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt,
    input  logic [4:0]               i_rd_idx,
    input  logic                     i_rd_wen,
    output logic                     o_post_valid,
    input  logic                     i_post_ready,
    output logic [CPU_WIDTH-1:0]     o_lsu_res,
    output logic [4:0]               o_rd_idx,
    output logic                     o_rd_wen,
    output logic                     o_misalign,
    output logic                     o_mem_req_valid,
    input  logic                     i_mem_req_ready,
    output logic [CPU_WIDTH-1:0]     o_mem_addr,
    output logic                     o_mem_wen,
    output logic [CPU_WIDTH-1:0]     o_mem_wdata,
    output logic [7:0]               o_mem_wmask,
    input  logic                     i_mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0]     i_mem_rdata
);

    lsu_state_e               state_q, state_d;
    logic [LSU_OPT_WIDTH-1:0] opt_q, opt_d;
    logic [CPU_WIDTH-1:0]     addr_q, addr_d;
    logic [CPU_WIDTH-1:0]     rs2_q, rs2_d;
    logic [CPU_WIDTH-1:0]     res_q, res_d;
    logic [4:0]               rd_idx_q, rd_idx_d;
    logic                     rd_wen_q, rd_wen_d;
    logic                     mis_q, mis_d;

    logic [CPU_WIDTH-1:0]     wdata;
    logic [7:0]               wmask;
    logic [CPU_WIDTH-1:0]     load_res;
    logic                     in_req;

    // Steering works off the latched opcode/address so request fields stay
    // stable while the memory side stalls.
    lsu_align #(
        .Width (CPU_WIDTH)
    ) u_align (
        .opt_i      (opt_q),
        .addr_lo_i  (addr_q[2:0]),
        .rs2_i      (rs2_q),
        .rdata_i    (i_mem_rdata),
        .wdata_o    (wdata),
        .wmask_o    (wmask),
        .load_res_o (load_res)
    );

    always_comb begin
        state_d  = state_q;
        opt_d    = opt_q;
        addr_d   = addr_q;
        rs2_d    = rs2_q;
        res_d    = res_q;
        rd_idx_d = rd_idx_q;
        rd_wen_d = rd_wen_q;
        mis_d    = mis_q;
        unique case (state_q)
            StIdle: begin
                if (i_pre_valid) begin
                    opt_d    = i_lsu_opt;
                    addr_d   = i_exu_res;
                    rs2_d    = i_rs2;
                    rd_idx_d = i_rd_idx;
                    rd_wen_d = i_rd_wen;
                    res_d    = '0;
                    mis_d    = 1'b0;
                    // Unknown opcodes are handled like NOP.
                    if (!is_load(i_lsu_opt) && !is_store(i_lsu_opt)) begin
                        state_d = StOut;
                        res_d   = i_exu_res;
                    end else if (misaligned(i_lsu_opt, i_exu_res[2:0])) begin
                        state_d = StOut;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (i_mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_mem_rsp_valid) begin
                    state_d = StOut;
                    res_d   = is_load(opt_q) ? load_res : '0;
                end
            end
            StOut: begin
                if (i_post_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            opt_q    <= '0;
            addr_q   <= '0;
            rs2_q    <= '0;
            res_q    <= '0;
            rd_idx_q <= '0;
            rd_wen_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opt_q    <= opt_d;
            addr_q   <= addr_d;
            rs2_q    <= rs2_d;
            res_q    <= res_d;
            rd_idx_q <= rd_idx_d;
            rd_wen_q <= rd_wen_d;
            mis_q    <= mis_d;
        end
    end

    assign in_req = (state_q == StReq);

    assign o_pre_ready     = (state_q == StIdle);
    assign o_post_valid    = (state_q == StOut);
    assign o_lsu_res       = res_q;
    assign o_rd_idx        = rd_idx_q;
    assign o_rd_wen        = rd_wen_q;
    assign o_misalign      = mis_q;
    assign o_mem_req_valid = in_req;
    assign o_mem_addr      = in_req ? {addr_q[CPU_WIDTH-1:3], 3'b000} : '0;
    assign o_mem_wen       = in_req & is_store(opt_q);
    assign o_mem_wdata     = in_req ? wdata : '0;
    assign o_mem_wmask     = in_req ? wmask : 8'h00;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    import lsu_pkg::*;

    logic        i_clk, i_rst;
    logic        i_pre_valid, o_pre_ready;
    logic [63:0] i_exu_res, i_rs2;
    logic [3:0]  i_lsu_opt;
    logic [4:0]  i_rd_idx, o_rd_idx;
    logic        i_rd_wen, o_rd_wen;
    logic        o_post_valid, i_post_ready;
    logic [63:0] o_lsu_res;
    logic        o_misalign;
    logic        o_mem_req_valid, i_mem_req_ready;
    logic [63:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_wen;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_rsp_valid;

    lsu dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_pre_valid     (i_pre_valid),
        .o_pre_ready     (o_pre_ready),
        .i_exu_res       (i_exu_res),
        .i_rs2           (i_rs2),
        .i_lsu_opt       (i_lsu_opt),
        .i_rd_idx        (i_rd_idx),
        .i_rd_wen        (i_rd_wen),
        .o_post_valid    (o_post_valid),
        .i_post_ready    (i_post_ready),
        .o_lsu_res       (o_lsu_res),
        .o_rd_idx        (o_rd_idx),
        .o_rd_wen        (o_rd_wen),
        .o_misalign      (o_misalign),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wen       (o_mem_wen),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_wmask     (o_mem_wmask),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rdata     (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          stall;  // cycles to hold i_mem_req_ready low
        bit          hold;   // withhold the response
    } req_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  idx;
        logic        wen;
        logic        mis;
        int          lat;    // expected accept-to-valid cycles, 0 = unchecked
        int          acc;
        int          pstall; // cycles to hold i_post_ready low
    } out_t;

    req_t req_q[$];
    out_t out_q[$];
    int   seq = 1;
    bit   late_rsp_go = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] opt, input logic [63:0] exu, input logic [63:0] rs2,
                         input bit has_req, input req_t rq,
                         input logic [63:0] exp_res, input logic exp_mis, input int lat,
                         input int pstall, input bit has_out);
        int   waited;
        out_t o;
        logic [4:0] idx;
        logic       wen;
        idx = seq[4:0];
        wen = seq[0];
        seq++;
        waited = 0;
        @(negedge i_clk);
        i_pre_valid = 1'b1;
        i_lsu_opt   = opt;
        i_exu_res   = exu;
        i_rs2       = rs2;
        i_rd_idx    = idx;
        i_rd_wen    = wen;
        while (!o_pre_ready && waited < 200) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_pre_ready) begin
            check("accept_timeout", 64'(o_pre_ready), 64'd1);
            i_pre_valid = 1'b0;
            return;
        end
        @(posedge i_clk);
        #1;
        i_pre_valid = 1'b0;
        i_exu_res   = 64'h0;
        i_rs2       = 64'h0;
        if (has_req) req_q.push_back(rq);
        if (has_out) begin
            o = '{exp_res, idx, wen, exp_mis, lat, cyc, pstall};
            out_q.push_back(o);
        end
    endtask

    task automatic do_nop(input logic [63:0] v);
        req_t r;
        r = '{64'h0, 1'b0, 64'h0, 8'h0, 64'h0, 0, 1'b0};
        issue(OptNop, v, 64'h1111, 1'b0, r, v, 1'b0, 1, 0, 1'b1);
    endtask

    task automatic do_load(input logic [3:0] opt, input logic [63:0] addr,
                           input logic [63:0] maddr, input logic [63:0] rdata,
                           input logic [63:0] exp);
        req_t r;
        r = '{maddr, 1'b0, 64'h0, 8'h00, rdata, 0, 1'b0};
        issue(opt, addr, 64'h0, 1'b1, r, exp, 1'b0, 3, 0, 1'b1);
    endtask

    task automatic do_store(input logic [3:0] opt, input logic [63:0] addr,
                            input logic [63:0] maddr, input logic [63:0] rs2,
                            input logic [63:0] wdata, input logic [7:0] wmask,
                            input int stall, input int pstall);
        req_t r;
        r = '{maddr, 1'b1, wdata, wmask, 64'hFFFF_0000_FFFF_0000, stall, 1'b0};
        issue(opt, addr, rs2, 1'b1, r, 64'h0, 1'b0, (stall == 0 && pstall == 0) ? 3 : 0,
              pstall, 1'b1);
    endtask

    task automatic do_mis(input logic [3:0] opt, input logic [63:0] addr);
        req_t r;
        r = '{64'h0, 1'b0, 64'h0, 8'h0, 64'h0, 0, 1'b0};
        issue(opt, addr, 64'hABCD, 1'b0, r, 64'h0, 1'b1, 1, 0, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_q.size() != 0 || req_q.size() != 0) && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_timeout", 64'(out_q.size() + req_q.size()), 64'd0);
        repeat (2) @(negedge i_clk);
    endtask

    // Memory model: checks each request against the queue, answers one cycle later.
    initial begin : mem_model
        bit          in_req, late_done;
        int          stall_left;
        req_t        r;
        logic [63:0] p_addr, p_wdata;
        logic [7:0]  p_mask;
        logic        p_wen;
        in_req = 0;
        late_done = 0;
        stall_left = 0;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata = 64'h0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                in_req = 0;
                i_mem_req_ready = 1'b0;
            end else if (late_rsp_go && !late_done) begin
                late_done = 1;
                i_mem_rsp_valid = 1'b1;
                i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
                @(posedge i_clk);
                #1;
                i_mem_rsp_valid = 1'b0;
            end else if (o_mem_req_valid) begin
                if (!in_req) begin
                    in_req = 1;
                    stall_left = (req_q.size() != 0) ? req_q[0].stall : 0;
                end else begin
                    check("req_stable_addr", o_mem_addr, p_addr);
                    check("req_stable_wdata", o_mem_wdata, p_wdata);
                    check("req_stable_wmask", 64'(o_mem_wmask), 64'(p_mask));
                    check("req_stable_wen", 64'(o_mem_wen), 64'(p_wen));
                end
                p_addr = o_mem_addr;
                p_wdata = o_mem_wdata;
                p_mask = o_mem_wmask;
                p_wen = o_mem_wen;
                if (stall_left > 0) begin
                    stall_left--;
                    i_mem_req_ready = 1'b0;
                end else begin
                    in_req = 0;
                    i_mem_req_ready = 1'b1;
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 64'd1, 64'd0);
                        r = '{64'h0, 1'b0, 64'h0, 8'h0, 64'h0, 0, 1'b0};
                    end else begin
                        r = req_q.pop_front();
                        check("req_addr", o_mem_addr, r.addr);
                        check("req_wen", 64'(o_mem_wen), 64'(r.wen));
                        check("req_wdata", o_mem_wdata, r.wdata);
                        check("req_wmask", 64'(o_mem_wmask), 64'(r.wmask));
                    end
                    @(posedge i_clk);
                    #1;
                    i_mem_req_ready = 1'b0;
                    if (!r.hold) begin
                        i_mem_rsp_valid = 1'b1;
                        i_mem_rdata = r.rdata;
                        @(posedge i_clk);
                        #1;
                        i_mem_rsp_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Downstream monitor: applies back-pressure, pops and compares on handshake.
    initial begin : out_monitor
        bit          in_out;
        int          stall_left;
        out_t        e;
        logic [63:0] p_res;
        logic [6:0]  p_side;
        in_out = 0;
        stall_left = 0;
        i_post_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                in_out = 0;
                i_post_ready = 1'b0;
            end else if (o_post_valid) begin
                if (!in_out) begin
                    in_out = 1;
                    stall_left = (out_q.size() != 0) ? out_q[0].pstall : 0;
                    if (out_q.size() != 0 && out_q[0].lat > 0)
                        check("latency", 64'(cyc - out_q[0].acc + 1), 64'(out_q[0].lat));
                end else begin
                    check("out_stable_res", o_lsu_res, p_res);
                    check("out_stable_side", 64'({o_rd_idx, o_rd_wen, o_misalign}),
                          64'(p_side));
                end
                p_res = o_lsu_res;
                p_side = {o_rd_idx, o_rd_wen, o_misalign};
                check("pre_ready_low", 64'(o_pre_ready), 64'd0);
                if (stall_left > 0) begin
                    stall_left--;
                    i_post_ready = 1'b0;
                end else begin
                    i_post_ready = 1'b1;
                    in_out = 0;
                    if (out_q.size() == 0) begin
                        check("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = out_q.pop_front();
                        check("out_res", o_lsu_res, e.res);
                        check("out_rd", 64'({o_rd_idx, o_rd_wen}), 64'({e.idx, e.wen}));
                        check("out_misalign", 64'(o_misalign), 64'(e.mis));
                    end
                end
            end else begin
                i_post_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        req_t r;
        i_rst = 1'b1;
        i_pre_valid = 1'b0;
        i_exu_res = 64'h0;
        i_rs2 = 64'h0;
        i_lsu_opt = OptNop;
        i_rd_idx = 5'd0;
        i_rd_wen = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_pre_ready", 64'(o_pre_ready), 64'd1);
        check("rst_post_valid", 64'(o_post_valid), 64'd0);
        check("rst_req_valid", 64'(o_mem_req_valid), 64'd0);
        check("rst_lsu_res", o_lsu_res, 64'h0);
        check("rst_side", 64'({o_rd_idx, o_rd_wen, o_misalign}), 64'd0);
        check("rst_mem_fields", 64'({o_mem_wen, o_mem_wmask}) | o_mem_addr | o_mem_wdata, 64'd0);
        i_rst = 1'b0;

        do_nop(64'hDEAD);
        do_load(OptLb, 64'h8000_0003, 64'h8000_0000, 64'h0000_0000_8000_0000,
                64'hFFFF_FFFF_FFFF_FF80);
        do_store(OptSh, 64'h8000_0006, 64'h8000_0000, 64'h1234,
                 64'h1234_0000_0000_0000, 8'hC0, 0, 0);
        do_mis(OptLw, 64'h8000_0006);
        do_load(OptLd, 64'h8000_0000, 64'h8000_0000, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF);
        do_load(OptLh, 64'h1002, 64'h1000, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
        do_load(OptLhu, 64'h1002, 64'h1000, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);
        do_load(OptLw, 64'h2004, 64'h2000, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_load(OptLwu, 64'h2004, 64'h2000, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        do_load(OptLbu, 64'h3007, 64'h3000, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);
        do_store(OptSb, 64'h4005, 64'h4000, 64'hFFEE, 64'h00FF_EE00_0000_0000, 8'h20, 0, 0);
        do_store(OptSw, 64'h5004, 64'h5000, 64'h1122_3344_5566_7788,
                 64'h5566_7788_0000_0000, 8'hF0, 0, 0);
        // Back-pressure on both the memory request and the output.
        do_store(OptSd, 64'h6008, 64'h6008, 64'hCAFE_BABE_1234_5678,
                 64'hCAFE_BABE_1234_5678, 8'hFF, 3, 2);
        do_mis(OptSh, 64'h7007);
        do_mis(OptLd, 64'h8001);
        do_nop(64'h5555_AAAA_5555_AAAA);
        drain();

        // Reset while waiting for a response; the late response must be dropped.
        r = '{64'h9010, 1'b0, 64'h0, 8'h00, 64'h0, 0, 1'b1};
        issue(OptLw, 64'h9010, 64'h0, 1'b1, r, 64'h0, 1'b0, 0, 0, 1'b0);
        repeat (2) @(negedge i_clk);
        check("pre_rst_in_wait", 64'({o_pre_ready, o_post_valid, o_mem_req_valid}), 64'd0);
        i_rst = 1'b1;
        #1;
        check("midrst_pre_ready", 64'(o_pre_ready), 64'd1);
        check("midrst_req_valid", 64'(o_mem_req_valid), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        late_rsp_go = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            check("late_rsp_ignored", 64'({o_pre_ready, o_post_valid}), 64'b10);
        end
        do_nop(64'h77);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
